// File: rtl/xbar_out_drain.sv
// Captures N crossbar output words on a rise of mvm_done and streams them, one per handshake, to the register file.
// Optional build macro XBAR_OUT_DRAIN_RELU_EN clamps negative words to zero as they are captured.
`ifndef XBAR_SIZE
`define XBAR_SIZE 4
`endif
`ifndef XBAR_OUT_BITS
`define XBAR_OUT_BITS 8
`endif

module xbar_out_drain #(
  parameter int N  = `XBAR_SIZE,
  parameter int W  = `XBAR_OUT_BITS,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mvm_done,
  input  logic [W-1:0]  xbar_output [0:N-1],
  input  logic [AW-1:0] base_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic          drain_done,
  output logic          overrun
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;

  state_t        state, state_nxt;
  logic          mvm_q;
  logic [IW-1:0] idx;
  logic [AW-1:0] base_q;
  logic [W-1:0]  buf_q [0:N-1];
  logic          rise, capture, xfer, last;

  function automatic logic [W-1:0] shape(input logic [W-1:0] d);
`ifdef XBAR_OUT_DRAIN_RELU_EN
    return d[W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  assign rise    = mvm_done & ~mvm_q;
  assign capture = rise & (state == IDLE);
  assign xfer    = (state == DRAIN) & out_ready;
  assign last    = (idx == IW'(N-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mvm_q   <= 1'b0;
      idx     <= '0;
      base_q  <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      mvm_q <= mvm_done;
      // any rise outside IDLE, including the FINISH->IDLE cycle, is a lost result
      if (rise && state != IDLE) overrun <= 1'b1;
      if (capture) begin
        base_q <= base_addr;
        idx    <= '0;
      end else if (xfer) begin
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < N; i++) buf_q[i] <= shape(xbar_output[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = DRAIN;
      DRAIN:   if (xfer && last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs are decoded from held state, so a stall keeps them stable
  assign out_valid  = (state == DRAIN);
  assign out_data   = out_valid ? buf_q[idx] : '0;
  assign out_addr   = out_valid ? base_q + AW'(idx) : '0;
  assign busy       = (state != IDLE);
  assign drain_done = (state == FINISH);
endmodule

// File: tb/tb_xbar_out_drain.sv
// Bench for xbar_out_drain: table-driven drains checked by a write scoreboard, plus overrun and reset corner sequences.
`timescale 1ns/1ps
module tb_xbar_out_drain;
  localparam int N = 4, W = 8, AW = 8;

  logic          clk = 1'b0, reset = 1'b0, mvm_done = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  xbar_output [0:N-1];
  logic [AW-1:0] base_addr = '0;
  logic          out_valid, busy, drain_done, overrun;
  logic [AW-1:0] out_addr;
  logic [W-1:0]  out_data;

  typedef struct {
    logic [AW-1:0] base;
    logic [W-1:0]  din [N];
    logic [15:0]   rdy;       // bit c-1 = out_ready in cycle c after capture
    logic [AW-1:0] exp_addr [N];
    logic [W-1:0]  exp_data [N];
    int            exp_done;
  } vec_t;

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; } wr_t;

  vec_t vecs [4];
  wr_t  sb [$];
  int   ncmp = 0, nfail = 0;

  xbar_out_drain #(.N(N), .W(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .mvm_done(mvm_done), .xbar_output(xbar_output),
    .base_addr(base_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy),
    .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input logic [W-1:0] d);
`ifdef XBAR_OUT_DRAIN_RELU_EN
    return d[W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // every valid cycle must present the scoreboard head; a handshake retires it
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb.size() == 0) check("unexpected_write", 32'(out_addr), 32'hFFFF_FFFF);
      else begin
        check("wr_addr", 32'(out_addr), 32'(sb[0].a));
        check("wr_data", 32'(out_data), 32'(sb[0].d));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic load(input vec_t v);
    xbar_output = v.din;
    base_addr   = v.base;
    for (int i = 0; i < N; i++) sb.push_back('{a: v.exp_addr[i], d: exp_word(v.exp_data[i])});
  endtask

  // entered #1 after the capture edge; returns on the negedge of the drain_done cycle
  task automatic wait_drain(input logic [15:0] rdy, input int exp_done, input int glitch_cyc);
    int cyc = 1;
    bit seen = 0;
    out_ready = rdy[0];
    @(negedge clk);
    check("first_valid", 32'(out_valid), 32'd1);
    while (cyc < 40) begin
      if (drain_done) begin seen = 1; break; end
      @(posedge clk); #1;
      cyc++;
      out_ready = (cyc <= 16) ? rdy[cyc-1] : 1'b1;
      if (cyc == glitch_cyc) begin
        mvm_done = 1'b1;
        base_addr = 8'h99;
        for (int i = 0; i < N; i++) xbar_output[i] = 8'hA5;
      end
      @(negedge clk);
      if (glitch_cyc != 0 && cyc == glitch_cyc) check("overrun_before", 32'(overrun), 32'd0);
    end
    check("drain_done_seen", 32'(seen), 32'd1);
    check("drain_done_cycle", 32'(cyc), 32'(exp_done));
    check("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic start(input vec_t v);
    @(posedge clk); #1;
    load(v);
    mvm_done = 1'b1;
    @(posedge clk); #1;
    mvm_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{base: 8'h10, din: '{8'h05, 8'hFD, 8'h07, 8'h00}, rdy: 16'hFFFF,
                exp_addr: '{8'h10, 8'h11, 8'h12, 8'h13}, exp_data: '{8'h05, 8'hFD, 8'h07, 8'h00}, exp_done: 5};
    vecs[1] = '{base: 8'hFE, din: '{8'h80, 8'h7F, 8'h01, 8'hFF}, rdy: 16'hFFFF,
                exp_addr: '{8'hFE, 8'hFF, 8'h00, 8'h01}, exp_data: '{8'h80, 8'h7F, 8'h01, 8'hFF}, exp_done: 5};
    vecs[2] = '{base: 8'h20, din: '{8'h11, 8'h22, 8'h33, 8'h44}, rdy: 16'hFF59,
                exp_addr: '{8'h20, 8'h21, 8'h22, 8'h23}, exp_data: '{8'h11, 8'h22, 8'h33, 8'h44}, exp_done: 8};
    vecs[3] = '{base: 8'hFF, din: '{8'hF0, 8'h0F, 8'hAA, 8'h55}, rdy: 16'hFFAA,
                exp_addr: '{8'hFF, 8'h00, 8'h01, 8'h02}, exp_data: '{8'hF0, 8'h0F, 8'hAA, 8'h55}, exp_done: 9};
    for (int i = 0; i < N; i++) xbar_output[i] = '0;

    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(out_addr), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(drain_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      start(vecs[v]);
      wait_drain(vecs[v].rdy, vecs[v].exp_done, 0);
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_overrun", 32'(overrun), 32'd0);
    end

    // rise during FINISH: flagged, never captured
    start(vecs[0]);
    wait_drain(16'hFFFF, 5, 0);
    mvm_done = 1'b1;
    @(posedge clk); #1;
    check("fin_overrun", 32'(overrun), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("fin_no_valid", 32'(out_valid), 32'd0);
    end
    mvm_done = 1'b0;
    #1 reset = 1'b0;
    #1 check("overrun_cleared", 32'(overrun), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // re-rise while index 2 is on the bus: original buffer must drain intact
    start(vecs[0]);
    wait_drain(16'hFFFF, 5, 3);
    check("mid_overrun", 32'(overrun), 32'd1);
    mvm_done = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // reset after two transfers aborts; mvm_done high at release captures at once
    start(vecs[1]);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_left", 32'(sb.size()), 32'd2);
    sb.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_no_done", 32'(drain_done), 32'd0);
    end
    load(vecs[0]);
    mvm_done = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 mvm_done = 1'b0;
    wait_drain(16'hFFFF, 5, 0);
    check("post_rst_overrun", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
